stack_seq: RTL and testbench
============================

Name: stack_seq

Overview:
- Stack access sequencer for the 8051 core; the other end of the stack pointer's push/pop interface.
- Accepts PUSH/POP/CALL/RET requests from the control unit and owns the SP register, including the SFR write at 81h.
- Issues the internal-RAM write and read cycles, and returns popped bytes or the 16-bit return PC.
- Sits between the decoder/control FSM and the internal data RAM port.

Parameters:
RST_SP, 8'h07, SP value after reset (empty stack).
SFR_SP_ADDR, 8'h81, direct address of the SP SFR.

Ports:
clock  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
start  input  1  request strobe; sampled only in IDLE.
op  input  2  00 PUSH byte, 01 POP byte, 10 CALL (push PC), 11 RET (pop PC).
push_data  input  8  byte for PUSH; sampled with start.
pc_in  input  16  return address for CALL; sampled with start.
sfr_wr  input  1  SFR byte-write strobe.
sfr_wr_bit  input  1  bit-write qualifier; a bit write never loads SP.
sfr_addr  input  8  SFR write address.
sfr_wdata  input  8  SFR write data.
ram_rdata  input  8  RAM read data, valid one cycle after ram_re.
ram_addr  output  8  RAM address.
ram_wdata  output  8  RAM write data.
ram_we  output  1  RAM write enable.
ram_re  output  1  RAM read enable.
busy  output  1  high while not in IDLE.
done  output  1  one-cycle pulse at operation completion.
pop_data  output  8  byte from last POP; held until next POP.
pc_out  output  16  PC from last RET; held until next RET.
sp_out  output  8  current SP value.
stack_err  output  1  guard violation flag; see Optional Feature.

Behaviour:
- Reset (any cycle, including mid-operation):
  - State returns to IDLE; sp=RST_SP.
  - ram_we, ram_re, done, busy, stack_err all 0.
  - ram_addr, ram_wdata, pop_data and pc_out are 0.
- SP write: sfr_wr & !sfr_wr_bit & sfr_addr==SFR_SP_ADDR loads sfr_wdata at the clock edge, in IDLE only.
  - While busy, SFR writes to SP are dropped.
- start with sfr write to SP in the same IDLE cycle: the operation is accepted and uses the newly written value (bypass).
- start while busy is ignored; there is no queueing.
- Let T be the start cycle. States: IDLE, WR1, WR2, RD1, RD2, CAP, DONE.
  - PUSH: T+1 WR1: ram_we=1, ram_addr=sp+1, ram_wdata=push_data; sp<=sp+1. T+2 DONE: done=1.
  - CALL:
    - T+1 WR1 writes pc_in[7:0] at sp+1.
    - T+2 WR2 writes pc_in[15:8] at sp+2.
    - sp increments each write (net +2). T+3 DONE.
  - POP: T+1 RD1: ram_re=1, ram_addr=sp; sp<=sp-1. T+2 CAP: pop_data<=ram_rdata. T+3 DONE; pop_data is valid with done.
  - RET:
    - T+1 RD1 reads sp (PCH); sp-1.
    - T+2 RD2 captures pc_out[15:8] and reads the new sp (PCL); sp-1.
    - T+3 CAP captures pc_out[7:0]. T+4 DONE.
- Handshake and idle outputs:
  - DONE returns to IDLE the next cycle; back-to-back start is allowed in that IDLE cycle.
  - ram_we and ram_re are never high together; both are 0 in IDLE, CAP and DONE.
- Arithmetic is 8-bit modulo 256 (no guard): FFh+1 -> 00h, 00h-1 -> FFh.
- sp_out always reflects the registered SP; it updates the cycle after each access.

Optional Feature:
- Macro: STACK_GUARD_EN.
- Defined: a guard check runs at accept in IDLE; violation conditions are
  - PUSH with sp==FFh;
  - CALL with sp>=FEh;
  - POP with sp<=RST_SP;
  - RET with sp<=RST_SP+1.
- On violation:
  - no RAM access and sp unchanged;
  - go straight to DONE at T+1 with done=1 and stack_err=1 (sticky until reset or next accepted start).
- Not defined: stack_err tied 0; wrap-around as described above.

Test Plan:
- Reset, then PUSH push_data=A5h -> T+1 ram_we=1 addr=08h data=A5h; T+2 done=1, sp_out=08h.
- From sp=07h, CALL pc_in=1234h -> T+1 write 34h@08h, T+2 write 12h@09h, T+3 done, sp_out=09h. Then RET -> reads 09h then 08h, T+4 done, pc_out=1234h, sp_out=07h.
- SFR write 81h<=30h with POP start in the same cycle, RAM[30h]=5Ah -> ram_re addr=30h, pop_data=5Ah at done, sp_out=2Fh. Repeat with sfr_wr_bit=1 -> SP not loaded, pop addr=07h.
- Reset asserted at CALL T+2 -> ram_we=0 immediately, busy=0, sp_out=07h. The next PUSH after release writes 08h.
- Boundaries, sp=FFh, PUSH 11h:
  - no guard -> write at 00h, sp_out=00h;
  - with STACK_GUARD_EN -> no write, done at T+1, stack_err=1, sp_out=FFh;
  - with guard, POP at sp=07h -> stack_err=1, no ram_re.
- start pulses during busy and an SFR SP write during busy -> both ignored; sp and the operation sequence are unaffected.

Source files
------------

// File: rtl/stack_seq.sv
// Stack access sequencer for the 8051 core: owns SP (SFR 81h) and sequences PUSH/POP/CALL/RET RAM cycles.
// Optional build macro STACK_GUARD_EN enables overflow/underflow guarding with a sticky stack_err flag.
module stack_seq #(
    parameter logic [7:0] RST_SP      = 8'h07,
    parameter logic [7:0] SFR_SP_ADDR = 8'h81
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [7:0]  push_data,
    input  logic [15:0] pc_in,
    input  logic        sfr_wr,
    input  logic        sfr_wr_bit,
    input  logic [7:0]  sfr_addr,
    input  logic [7:0]  sfr_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    output logic        ram_re,
    output logic        busy,
    output logic        done,
    output logic [7:0]  pop_data,
    output logic [15:0] pc_out,
    output logic [7:0]  sp_out,
    output logic        stack_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR1, S_WR2, S_RD1, S_RD2, S_CAP, S_DONE
    } state_t;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    state_t      state_q, state_d;
    logic [7:0]  sp_q, sp_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] wbuf_q, wbuf_d;
    logic [7:0]  pop_q, pop_d;
    logic [15:0] pc_q, pc_d;
    logic        err_q, err_d;

    logic        sp_wr;
    logic [7:0]  sp_eff;
    logic        guard_viol;

    // An SP write in the accept cycle bypasses into the operation's address math.
    assign sp_wr  = (state_q == S_IDLE) & sfr_wr & ~sfr_wr_bit & (sfr_addr == SFR_SP_ADDR);
    assign sp_eff = sp_wr ? sfr_wdata : sp_q;

`ifdef STACK_GUARD_EN
    always_comb begin
        case (op)
            OP_PUSH: guard_viol = (sp_eff == 8'hFF);
            OP_CALL: guard_viol = (sp_eff >= 8'hFE);
            OP_POP:  guard_viol = (sp_eff <= RST_SP);
            default: guard_viol = (sp_eff <= RST_SP + 8'd1);
        endcase
    end
`else
    assign guard_viol = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) begin
                if (guard_viol)                          state_d = S_DONE;
                else if (op == OP_PUSH || op == OP_CALL) state_d = S_WR1;
                else                                     state_d = S_RD1;
            end
            S_WR1:   state_d = (op_q == OP_CALL) ? S_WR2 : S_DONE;
            S_WR2:   state_d = S_DONE;
            S_RD1:   state_d = (op_q == OP_RET) ? S_RD2 : S_CAP;
            S_RD2:   state_d = S_CAP;
            S_CAP:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = 8'h00;
        ram_wdata = 8'h00;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        case (state_q)
            S_WR1: begin
                ram_we    = 1'b1;
                ram_addr  = sp_q + 8'd1;
                ram_wdata = wbuf_q[7:0];
            end
            S_WR2: begin
                ram_we    = 1'b1;
                ram_addr  = sp_q + 8'd1;
                ram_wdata = wbuf_q[15:8];
            end
            S_RD1, S_RD2: begin
                ram_re   = 1'b1;
                ram_addr = sp_q;
            end
            default: ;
        endcase
    end

    // Datapath next-state: SP moves one step per RAM access, read data lands a cycle later.
    always_comb begin
        sp_d   = sp_q;
        op_d   = op_q;
        wbuf_d = wbuf_q;
        pop_d  = pop_q;
        pc_d   = pc_q;
        err_d  = err_q;
        case (state_q)
            S_IDLE: begin
                sp_d = sp_eff;
                if (start) begin
                    op_d   = op;
                    wbuf_d = (op == OP_CALL) ? pc_in : {8'h00, push_data};
                    err_d  = guard_viol;
                end
            end
            S_WR1, S_WR2: sp_d = sp_q + 8'd1;
            S_RD1:        sp_d = sp_q - 8'd1;
            S_RD2: begin
                sp_d       = sp_q - 8'd1;
                pc_d[15:8] = ram_rdata;
            end
            S_CAP: begin
                if (op_q == OP_RET) pc_d[7:0] = ram_rdata;
                else                pop_d     = ram_rdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sp_q   <= RST_SP;
            op_q   <= OP_PUSH;
            wbuf_q <= 16'h0000;
            pop_q  <= 8'h00;
            pc_q   <= 16'h0000;
            err_q  <= 1'b0;
        end else begin
            sp_q   <= sp_d;
            op_q   <= op_d;
            wbuf_q <= wbuf_d;
            pop_q  <= pop_d;
            pc_q   <= pc_d;
            err_q  <= err_d;
        end
    end

    assign pop_data  = pop_q;
    assign pc_out    = pc_q;
    assign sp_out    = sp_q;
    assign stack_err = err_q;

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: directed plan steps plus random ops against an array-based stack model.
module tb_stack_seq;

    localparam logic [7:0] RST = 8'h07;
    localparam logic [7:0] SFR = 8'h81;
`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clock = 1'b0, reset = 1'b0, start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [7:0]  push_data = 8'h00, sfr_addr = 8'h00, sfr_wdata = 8'h00;
    logic [15:0] pc_in = 16'h0000;
    logic        sfr_wr = 1'b0, sfr_wr_bit = 1'b0;
    logic [7:0]  ram_rdata = 8'h00;
    logic [7:0]  ram_addr, ram_wdata, pop_data, sp_out;
    logic        ram_we, ram_re, busy, done, stack_err;
    logic [15:0] pc_out;

    stack_seq dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .push_data(push_data),
        .pc_in(pc_in), .sfr_wr(sfr_wr), .sfr_wr_bit(sfr_wr_bit), .sfr_addr(sfr_addr),
        .sfr_wdata(sfr_wdata), .ram_rdata(ram_rdata), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re), .busy(busy),
        .done(done), .pop_data(pop_data), .pc_out(pc_out), .sp_out(sp_out),
        .stack_err(stack_err)
    );

    always #5 clock = ~clock;

    // Internal RAM: synchronous write, read data one cycle after ram_re.
    logic [7:0] ram [256] = '{default: 8'h00};
    always @(posedge clock) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram_re ? ram[ram_addr] : 8'h00;
    end

    // Reference model state.
    logic [7:0]  ref_mem [256] = '{default: 8'h00};
    logic [7:0]  ref_sp = RST;
    logic [7:0]  ref_pop = 8'h00;
    logic [15:0] ref_pc = 16'h0000;
    logic        ref_err = 1'b0;

    int tests = 0;
    int fails = 0;

    task automatic chkb(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit viol(input logic [1:0] o, input logic [7:0] s);
        bit c;
        case (o)
            2'b00:   c = (s == 8'hFF);
            2'b10:   c = (s >= 8'hFE);
            2'b01:   c = (s <= RST);
            default: c = (s <= RST + 8'd1);
        endcase
        return GUARD && c;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        start = 1'b0; sfr_wr = 1'b0; sfr_wr_bit = 1'b0;
    endtask

    // Garbage on start and SP writes while busy; all of it must be dropped.
    task automatic noise(input bit en);
        if (en) begin
            start = 1'($urandom); op = 2'($urandom); push_data = 8'($urandom);
            pc_in = 16'($urandom); sfr_wr = 1'b1; sfr_wr_bit = 1'b0;
            sfr_addr = SFR; sfr_wdata = 8'($urandom);
        end
    endtask

    task automatic cyc(input string tag, input logic we, input logic re, input logic [7:0] addr,
                       input logic [7:0] wd, input logic dn, input logic [7:0] sp);
        chkb({tag, "/busy"}, busy, 1'b1);
        chkb({tag, "/done"}, done, dn);
        chkb({tag, "/we"}, ram_we, we);
        chkb({tag, "/re"}, ram_re, re);
        if (we || re) chk8({tag, "/addr"}, ram_addr, addr);
        if (we)       chk8({tag, "/wdata"}, ram_wdata, wd);
        chk8({tag, "/sp"}, sp_out, sp);
        chkb({tag, "/err"}, stack_err, ref_err);
    endtask

    task automatic idle_chk(input string tag);
        chkb({tag, "/idle_busy"}, busy, 1'b0);
        chkb({tag, "/idle_done"}, done, 1'b0);
        chkb({tag, "/idle_we"}, ram_we, 1'b0);
        chkb({tag, "/idle_re"}, ram_re, 1'b0);
        chk8({tag, "/idle_sp"}, sp_out, ref_sp);
        chkb({tag, "/idle_err"}, stack_err, ref_err);
        chk8({tag, "/idle_pop"}, pop_data, ref_pop);
        chk16({tag, "/idle_pc"}, pc_out, ref_pc);
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] d,
                         input logic [15:0] pc, input bit sfr_en, input bit sfr_bit,
                         input logic [7:0] sv, input bit nz);
        logic [7:0] e, ep1, ep2, em1, em2;
        bit v;
        e = (sfr_en && !sfr_bit) ? sv : ref_sp;
        ep1 = e + 8'd1; ep2 = e + 8'd2; em1 = e - 8'd1; em2 = e - 8'd2;
        v = viol(o, e);
        start = 1'b1; op = o; push_data = d; pc_in = pc;
        sfr_wr = sfr_en; sfr_wr_bit = sfr_bit; sfr_addr = SFR; sfr_wdata = sv;
        step(); quiet();
        ref_err = v;
        if (v) begin
            cyc({tag, "/guard"}, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, e);
            ref_sp = e;
            noise(nz); step();
        end else begin
            case (o)
                2'b00: begin
                    cyc({tag, "/wr1"}, 1'b1, 1'b0, ep1, d, 1'b0, e);
                    ref_mem[ep1] = d;
                    noise(nz); step();
                    cyc({tag, "/done"}, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ep1);
                    ref_sp = ep1;
                    noise(nz); step();
                end
                2'b10: begin
                    cyc({tag, "/wr1"}, 1'b1, 1'b0, ep1, pc[7:0], 1'b0, e);
                    ref_mem[ep1] = pc[7:0];
                    noise(nz); step();
                    cyc({tag, "/wr2"}, 1'b1, 1'b0, ep2, pc[15:8], 1'b0, ep1);
                    ref_mem[ep2] = pc[15:8];
                    noise(nz); step();
                    cyc({tag, "/done"}, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, ep2);
                    ref_sp = ep2;
                    noise(nz); step();
                end
                2'b01: begin
                    cyc({tag, "/rd1"}, 1'b0, 1'b1, e, 8'h00, 1'b0, e);
                    noise(nz); step();
                    cyc({tag, "/cap"}, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, em1);
                    noise(nz); step();
                    ref_pop = ref_mem[e];
                    cyc({tag, "/done"}, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, em1);
                    chk8({tag, "/pop_data"}, pop_data, ref_pop);
                    ref_sp = em1;
                    noise(nz); step();
                end
                default: begin
                    cyc({tag, "/rd1"}, 1'b0, 1'b1, e, 8'h00, 1'b0, e);
                    noise(nz); step();
                    cyc({tag, "/rd2"}, 1'b0, 1'b1, em1, 8'h00, 1'b0, em1);
                    noise(nz); step();
                    cyc({tag, "/cap"}, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, em2);
                    noise(nz); step();
                    ref_pc = {ref_mem[e], ref_mem[em1]};
                    cyc({tag, "/done"}, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, em2);
                    chk16({tag, "/pc_out"}, pc_out, ref_pc);
                    ref_sp = em2;
                    noise(nz); step();
                end
            endcase
        end
        idle_chk(tag);
        quiet();
    endtask

    task automatic sfr_raw(input string tag, input logic [7:0] a, input bit b, input logic [7:0] v);
        sfr_wr = 1'b1; sfr_wr_bit = b; sfr_addr = a; sfr_wdata = v;
        step(); quiet();
        if (a == SFR && !b) ref_sp = v;
        chk8({tag, "/sp"}, sp_out, ref_sp);
    endtask

    // Called just after a rising edge; checks outputs go quiet asynchronously.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        ref_sp = RST; ref_err = 1'b0; ref_pop = 8'h00; ref_pc = 16'h0000;
        chkb({tag, "/we"}, ram_we, 1'b0);
        chkb({tag, "/re"}, ram_re, 1'b0);
        chkb({tag, "/busy"}, busy, 1'b0);
        chkb({tag, "/done"}, done, 1'b0);
        chkb({tag, "/err"}, stack_err, 1'b0);
        chk8({tag, "/addr"}, ram_addr, 8'h00);
        chk8({tag, "/wdata"}, ram_wdata, 8'h00);
        chk8({tag, "/sp"}, sp_out, RST);
        chk8({tag, "/pop"}, pop_data, 8'h00);
        chk16({tag, "/pc"}, pc_out, 16'h0000);
        quiet();
        step();
        #2 reset = 1'b1;
        step();
        idle_chk({tag, "/after"});
    endtask

    initial begin
        int k;
        step();
        do_reset("por");

        // Plan: PUSH A5h, pop it back, then CALL/RET round trip with busy-time noise.
        do_op("push_a5", 2'b00, 8'hA5, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
        do_op("pop_a5",  2'b01, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
        do_op("call",    2'b10, 8'h00, 16'h1234, 1'b0, 1'b0, 8'h00, 1'b1);
        do_op("ret",     2'b11, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1);

        // SP bypass: seed 30h/31h, then POP with SP<=30h in the start cycle.
        sfr_raw("sp2f", SFR, 1'b0, 8'h2F);
        do_op("seed30", 2'b00, 8'h5A, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
        do_op("seed31", 2'b00, 8'h77, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
        do_op("pop_byp", 2'b01, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h30, 1'b0);
        sfr_raw("sfr_bit", SFR, 1'b1, 8'h99);
        sfr_raw("sfr_80h", 8'h80, 1'b0, 8'h99);
        do_reset("rst1");
        do_op("pop_bitwr", 2'b01, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h30, 1'b0);

        // Reset in the middle of a CALL, at its second write.
        do_reset("rst2");
        start = 1'b1; op = 2'b10; pc_in = 16'hABCD;
        step(); quiet();
        ref_err = 1'b0;
        cyc("midcall/wr1", 1'b1, 1'b0, 8'h08, 8'hCD, 1'b0, 8'h07);
        ref_mem[8'h08] = 8'hCD;
        step();
        cyc("midcall/wr2", 1'b1, 1'b0, 8'h09, 8'hAB, 1'b0, 8'h08);
        do_reset("rst_mid");
        do_op("push_post", 2'b00, 8'h3C, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);

        // Boundaries.
        sfr_raw("spff", SFR, 1'b0, 8'hFF);
        do_op("push_ff", 2'b00, 8'h11, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
        do_op("call_fe", 2'b10, 8'h00, 16'hBEEF, 1'b1, 1'b0, 8'hFE, 1'b0);
        do_reset("rst3");
        do_op("pop_07", 2'b01, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0);
        do_op("ret_08", 2'b11, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h08, 1'b0);
        do_op("pop_00", 2'b01, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0);
        do_op("push_ok", 2'b00, 8'h42, 16'h0000, 1'b1, 1'b0, 8'h40, 1'b0);

        for (int i = 0; i < 80; i++) begin
            k = int'($urandom_range(0, 9));
            if (k == 0)
                sfr_raw("rnd_sfr", ($urandom_range(0, 3) == 0) ? 8'h80 : SFR,
                        1'($urandom_range(0, 3) == 0), 8'($urandom));
            else if (k == 1)
                sfr_raw("rnd_top", SFR, 1'b0, 8'($urandom_range(8'hF8, 8'hFF)));
            else
                do_op("rnd", 2'($urandom), 8'($urandom), 16'($urandom), k == 2,
                      1'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
